// File: rtl/fxp_fp_pkg.sv
// fxp_fp_pkg: shared IEEE-754 single-precision constants and field layout
package fxp_fp_pkg;
    localparam int FP32_MANT_W = 23;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_BIAS = 127;
    typedef struct packed {
        logic sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MANT_W-1:0] mant;
    } fp32_t;
endpackage

// File: rtl/lead_one_detect.sv
// lead_one_detect: combinational priority encoder giving the index of the highest set bit
module lead_one_detect #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         a_i,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     zero
);
    localparam int IW = $clog2(WIDTH);
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (a_i[i]) idx = IW'(i);
        zero = ~|a_i;
    end
endmodule

// File: rtl/fixed_to_float_pipe.sv
// fixed_to_float_pipe: 3-stage fixed-point to FP32 converter with valid/ready flow control
module fixed_to_float_pipe
    import fxp_fp_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int POS_WIDTH = $clog2(IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [POS_WIDTH-1:0] in_fixpos,
    input  logic                 in_signed,
    input  logic                 in_rne,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic                 out_inexact
);
    logic                 adv;
    logic                 v1_q, v2_q, v3_q;
    logic                 sign1_q, sign2_q, rne1_q, rne2_q, zero2_q;
    logic [IN_WIDTH-1:0]  mag_d, mag1_q, mag2_q;
    logic [POS_WIDTH-1:0] pos1_q, pos2_q, lead_d, lead2_q;
    logic                 zero_d, sign_d;
    logic [31:0]          out_data_q, out_data_d;
    logic                 out_inexact_q, out_inexact_d;
    logic [IN_WIDTH-1:0]  norm;
    logic [IN_WIDTH+FP32_MANT_W:0] wide;
    logic [FP32_MANT_W-1:0] frac;
    logic [FP32_MANT_W:0]   frac_r;
    logic                 guard, sticky, inc;
    logic [9:0]           exp_w;
    fp32_t                res;

    assign adv = out_ready | ~v3_q;
    assign in_ready = adv;
    assign out_valid = v3_q;
    assign out_data = out_data_q;
    assign out_inexact = out_inexact_q;
    assign sign_d = in_signed & in_data[IN_WIDTH-1];
    assign mag_d = sign_d ? -in_data : in_data;

    lead_one_detect #(.WIDTH(IN_WIDTH)) u_lod (
        .a_i  (mag1_q),
        .idx  (lead_d),
        .zero (zero_d)
    );

    // Shifting by (IN_WIDTH - lead) drops the implicit leading one off the top
    always_comb begin
        norm = mag2_q << (IN_WIDTH - int'(lead2_q));
        wide = {norm, {(FP32_MANT_W+1){1'b0}}};
        frac = wide[IN_WIDTH+FP32_MANT_W -: FP32_MANT_W];
        guard = wide[IN_WIDTH];
        sticky = |wide[IN_WIDTH-1:0];
        inc = rne2_q & guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + (FP32_MANT_W+1)'(inc);
        exp_w = 10'(FP32_BIAS) + 10'(lead2_q) - 10'(pos2_q) + 10'(frac_r[FP32_MANT_W]);
        res = '{sign: sign2_q, exp: exp_w[7:0], mant: frac_r[FP32_MANT_W-1:0]};
        out_data_d = (zero2_q | (|exp_w[9:8])) ? 32'h0 : res;
        out_inexact_d = ~zero2_q & (guard | sticky);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            out_data_q <= 32'h0;
            out_inexact_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
            sign1_q <= sign_d;
            mag1_q <= mag_d;
            pos1_q <= in_fixpos;
            rne1_q <= in_rne;
            v2_q <= v1_q;
            sign2_q <= sign1_q;
            mag2_q <= mag1_q;
            pos2_q <= pos1_q;
            rne2_q <= rne1_q;
            lead2_q <= lead_d;
            zero2_q <= zero_d;
            v3_q <= v2_q;
            out_data_q <= out_data_d;
            out_inexact_q <= out_inexact_d;
        end
    end
endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// tb_fixed_to_float_pipe: directed vectors with a queue scoreboard and an independent output monitor
module tb_fixed_to_float_pipe;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, in_signed = 0, in_rne = 0;
    logic [31:0] in_data = 0;
    logic [4:0]  in_fixpos = 0;
    logic        out_valid, out_ready = 1, out_inexact;
    logic [31:0] out_data;
    int          total = 0, pass = 0, cyc = 0, rdy_mode = 0, k = 0;
    logic        held_v = 0, held_x = 0;
    logic [31:0] held_d = 0;

    typedef struct {
        logic [31:0] d;
        logic        x;
        int          t;
        bit          lat;
    } exp_t;
    exp_t sb[$];

    fixed_to_float_pipe #(.IN_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_fixpos(in_fixpos), .in_signed(in_signed), .in_rne(in_rne),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? pat[3 - (k % 4)] : 1'b0;
        k++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) held_v = 0;
        else if (out_valid) begin
            if (held_v) begin
                chk("stall_data", out_data, held_d);
                chk("stall_inexact", {31'd0, out_inexact}, {31'd0, held_x});
            end
            if (out_ready) begin
                held_v = 0;
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_output: got %h expected no output", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("data", out_data, e.d);
                    chk("inexact", {31'd0, out_inexact}, {31'd0, e.x});
                    if (e.lat) chk("latency", 32'(cyc - e.t), 32'd3);
                end
            end else begin
                held_v = 1;
                held_d = out_data;
                held_x = out_inexact;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] fp, input logic s, input logic r,
                        input logic [31:0] ed, input logic ex, input bit push, input bit lat);
        int n, t;
        in_valid = 1; in_data = d; in_fixpos = fp; in_signed = s; in_rne = r;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            total++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 100 cycles");
        end else begin
            t = cyc;
            @(posedge clk);
            #1;
            if (push) sb.push_back('{ed, ex, t, lat});
        end
    endtask

    task automatic single(input logic [31:0] d, input logic [4:0] fp, input logic s, input logic r,
                          input logic [31:0] ed, input logic ex);
        send(d, fp, s, r, ed, ex, 1, 1);
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_inexact", {31'd0, out_inexact}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        single(32'h0001_0000, 16, 1, 1, 32'h3F80_0000, 0);
        single(32'hFFFF_0000, 16, 1, 1, 32'hBF80_0000, 0);
        single(32'h8000_0000, 0, 1, 1, 32'hCF00_0000, 0);
        single(32'h8000_0000, 31, 0, 1, 32'h3F80_0000, 0);
        single(32'h0100_0003, 0, 0, 1, 32'h4B80_0002, 1);
        single(32'h0100_0003, 0, 0, 0, 32'h4B80_0001, 1);
        single(32'h0100_0001, 0, 0, 1, 32'h4B80_0000, 1);
        single(32'hFFFF_FFFF, 0, 0, 1, 32'h4F80_0000, 1);
        single(32'hFFFF_FFFF, 0, 1, 1, 32'hBF80_0000, 0);
        single(32'h0000_0000, 0, 0, 1, 32'h0000_0000, 0);
        single(32'h0000_0000, 0, 1, 1, 32'h0000_0000, 0);
        // Stream of small integers under a 1,0,0,1 ready pattern
        rdy_mode = 1;
        send(1, 0, 0, 1, 32'h3F80_0000, 0, 1, 0);
        send(2, 0, 0, 1, 32'h4000_0000, 0, 1, 0);
        send(3, 0, 0, 1, 32'h4040_0000, 0, 1, 0);
        send(4, 0, 0, 1, 32'h4080_0000, 0, 1, 0);
        send(5, 0, 0, 1, 32'h40A0_0000, 0, 1, 0);
        send(6, 0, 0, 1, 32'h40C0_0000, 0, 1, 0);
        send(7, 0, 0, 1, 32'h40E0_0000, 0, 1, 0);
        send(8, 0, 0, 1, 32'h4100_0000, 0, 1, 0);
        in_valid = 0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        chk("stream_drained", 32'(sb.size()), 32'd0);
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        // Three beats in flight, output stalled, then reset
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(100, 0, 0, 1, 0, 0, 0, 0);
        send(200, 0, 0, 1, 0, 0, 0, 0);
        send(300, 0, 0, 1, 0, 0, 0, 0);
        in_valid = 0;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        single(32'h0000_0003, 1, 0, 1, 32'h3FC0_0000, 0);
        repeat (5) @(posedge clk);
        chk("final_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
